// File: rtl/ov7670_capture_ctrl.sv
// OV7670 frame capture sequencer: arms on request, gates one clean frame,
// checks geometry, commits good frames by ping-pong bank swap.
// Optional macro CAP_CONTINUOUS_EN: keep re-arming after each commit.
module ov7670_capture_ctrl #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int PIX_CNT_W  = $clog2(IMG_WIDTH*IMG_HEIGHT+1),
    parameter int LINE_CNT_W = $clog2(IMG_HEIGHT+1)
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  href,
    input  logic                  pix_we,
    input  logic                  cap_req,
    input  logic                  rd_release,
    output logic                  wr_en,
    output logic                  wr_bank,
    output logic                  rd_bank,
    output logic                  frame_rdy,
    output logic                  frame_err,
    output logic                  frame_drop,
    output logic                  busy,
    output logic [LINE_CNT_W-1:0] line_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_COMMIT
    } state_t;

    localparam logic [LINE_CNT_W-1:0] LINES_GOOD = LINE_CNT_W'(IMG_HEIGHT);
    localparam logic [PIX_CNT_W-1:0]  PIX_GOOD   = PIX_CNT_W'(IMG_WIDTH*IMG_HEIGHT);
    localparam logic [LINE_CNT_W-1:0] LINE_MAX   = '1;
    localparam logic [PIX_CNT_W-1:0]  PIX_MAX    = '1;

    state_t                state_q, state_d;
    logic                  vsync_q, href_q;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [PIX_CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  frame_rdy_q, frame_rdy_d;
    logic                  frame_err_q, frame_err_d;
    logic                  frame_drop_q, frame_drop_d;
`ifdef CAP_CONTINUOUS_EN
    logic                  cont_q, cont_d;
`endif

    logic vs_fall, vs_rise, href_rise, good;

    assign vs_fall   = vsync_q & ~vsync;
    assign vs_rise   = ~vsync_q & vsync;
    assign href_rise = ~href_q & href;
    assign good      = (line_cnt_q == LINES_GOOD) && (pix_cnt_q == PIX_GOOD);

    assign wr_en      = (state_q == S_CAPTURE);
    assign busy       = (state_q != S_IDLE);
    assign wr_bank    = wr_bank_q;
    assign rd_bank    = ~wr_bank_q;
    assign frame_rdy  = frame_rdy_q;
    assign frame_err  = frame_err_q;
    assign frame_drop = frame_drop_q;
    assign line_cnt   = line_cnt_q;

    // Next-state: sequencing, frame counters, commit/bank-swap decision
    always_comb begin
        state_d      = state_q;
        line_cnt_d   = line_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        wr_bank_d    = wr_bank_q;
        frame_rdy_d  = frame_rdy_q & ~rd_release;
        frame_err_d  = 1'b0;
        frame_drop_d = 1'b0;
`ifdef CAP_CONTINUOUS_EN
        cont_d       = cont_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cap_req) begin
                    state_d = S_ARM;
`ifdef CAP_CONTINUOUS_EN
                    cont_d  = 1'b1;
`endif
                end
            end
            S_ARM: begin
`ifdef CAP_CONTINUOUS_EN
                if (cap_req) cont_d = 1'b0;
`endif
                if (vs_fall) begin
                    state_d    = S_CAPTURE;
                    line_cnt_d = '0;
                    pix_cnt_d  = '0;
                end
            end
            S_CAPTURE: begin
`ifdef CAP_CONTINUOUS_EN
                if (cap_req) cont_d = 1'b0;
`endif
                if (href_rise && line_cnt_q != LINE_MAX)
                    line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
                if (pix_we && pix_cnt_q != PIX_MAX)
                    pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
                if (vs_rise) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                if (!good) begin
                    frame_err_d = 1'b1;
                end else if (!frame_rdy_q || rd_release) begin
                    wr_bank_d   = ~wr_bank_q;
                    frame_rdy_d = 1'b1;
                end else begin
                    frame_drop_d = 1'b1;
                end
`ifdef CAP_CONTINUOUS_EN
                state_d = (cont_q && !cap_req) ? S_ARM : S_IDLE;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            line_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            wr_bank_q    <= 1'b0;
            frame_rdy_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_drop_q <= 1'b0;
`ifdef CAP_CONTINUOUS_EN
            cont_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync;
            href_q       <= href;
            line_cnt_q   <= line_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            wr_bank_q    <= wr_bank_d;
            frame_rdy_q  <= frame_rdy_d;
            frame_err_q  <= frame_err_d;
            frame_drop_q <= frame_drop_d;
`ifdef CAP_CONTINUOUS_EN
            cont_q       <= cont_d;
`endif
        end
    end

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Scoreboard bench for ov7670_capture_ctrl (IMG_WIDTH=4, IMG_HEIGHT=3).
// Frame-level reference model predicts commit outcomes; monitor checks them.
module tb_ov7670_capture_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int LW = $clog2(H+1);
    localparam int PW = $clog2(W*H+1);
    localparam int LMAX = (1 << LW) - 1;
    localparam int PMAX = (1 << PW) - 1;
`ifdef CAP_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic pclk = 1'b0;
    logic reset = 1'b1;
    logic vsync = 1'b1;
    logic href = 1'b0;
    logic pix_we = 1'b0;
    logic cap_req = 1'b0;
    logic rd_release = 1'b0;
    logic wr_en, wr_bank, rd_bank, frame_rdy;
    logic frame_err, frame_drop, busy;
    logic [LW-1:0] line_cnt;

    ov7670_capture_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .pclk(pclk), .reset(reset), .vsync(vsync), .href(href),
        .pix_we(pix_we), .cap_req(cap_req), .rd_release(rd_release),
        .wr_en(wr_en), .wr_bank(wr_bank), .rd_bank(rd_bank),
        .frame_rdy(frame_rdy), .frame_err(frame_err),
        .frame_drop(frame_drop), .busy(busy), .line_cnt(line_cnt)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int kind;
        int bank;
        int rdy;
        int lc;
    } exp_t;

    exp_t exp_q[$];
    int n_pass = 0;
    int n_total = 0;

    bit m_bank, m_rdy, m_armed, m_capt, m_cont;
    bit exp_wr_en = 1'b0;
    logic prev_bank = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    // Monitor: wr_en every cycle; pop expected record on each commit event
    always @(negedge pclk) begin
        if (reset) begin
            prev_bank <= 1'b0;
        end else begin
            chk("wr_en", int'(wr_en), int'(exp_wr_en));
            if (frame_err || frame_drop || wr_bank != prev_bank) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    exp_t e;
                    int k;
                    e = exp_q.pop_front();
                    k = frame_err ? 1 : (frame_drop ? 2 : 0);
                    chk("event_kind", k, e.kind);
                    chk("wr_bank", int'(wr_bank), e.bank);
                    chk("rd_bank", int'(rd_bank), 1 - e.bank);
                    chk("frame_rdy", int'(frame_rdy), e.rdy);
                    chk("line_cnt", int'(line_cnt), e.lc);
                end
            end
            prev_bank <= wr_bank;
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: got running expected done");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        m_bank = 0; m_rdy = 0; m_armed = 0; m_capt = 0; m_cont = 0;
        exp_wr_en = 1'b0;
        @(negedge pclk);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_bank", int'(wr_bank), 0);
        chk("rst_rd_bank", int'(rd_bank), 1);
        chk("rst_frame_rdy", int'(frame_rdy), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_frame_drop", int'(frame_drop), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_line_cnt", int'(line_cnt), 0);
        tick();
        reset = 1'b0;
    endtask

    task automatic req();
        cap_req = 1'b1;
        if (!m_armed && !m_capt) begin
            m_armed = 1;
            m_cont = CONT;
        end else begin
            m_cont = 0;
        end
        tick();
        cap_req = 1'b0;
    endtask

    task automatic release_rd();
        rd_release = 1'b1;
        m_rdy = 0;
        tick();
        rd_release = 1'b0;
        @(negedge pclk);
        chk("release_rdy", int'(frame_rdy), 0);
    endtask

    task automatic frame(input int nl, input int pl[4], input bit rel,
                         input bit mid);
        int sum = 0;
        int lc, pc;
        exp_t e;
        vsync = 1'b1;
        repeat ($urandom_range(2, 4)) tick();
        vsync = 1'b0;
        if (m_armed) begin
            m_capt = 1;
            m_armed = 0;
        end
        tick();
        exp_wr_en = m_capt;
        for (int l = 0; l < nl; l++) begin
            href = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            href = 1'b1;
            tick();
            if (mid && l == 1) req();
            for (int p = 0; p < pl[l]; p++) begin
                pix_we = 1'b1;
                tick();
                pix_we = 1'b0;
                repeat ($urandom_range(0, 1)) tick();
            end
            sum += pl[l];
        end
        href = 1'b0;
        repeat (2) tick();
        vsync = 1'b1;
        tick();
        exp_wr_en = 1'b0;
        rd_release = rel;
        if (m_capt) begin
            lc = (nl > LMAX) ? LMAX : nl;
            pc = (sum > PMAX) ? PMAX : sum;
            if (lc == H && pc == W*H) begin
                if (!m_rdy || rel) begin
                    m_bank = ~m_bank;
                    m_rdy = 1;
                    e.kind = 0;
                end else begin
                    e.kind = 2;
                end
            end else begin
                if (rel) m_rdy = 0;
                e.kind = 1;
            end
            e.bank = int'(m_bank);
            e.rdy = int'(m_rdy);
            e.lc = lc;
            exp_q.push_back(e);
            m_capt = 0;
            if (m_cont) m_armed = 1;
        end else if (rel) begin
            m_rdy = 0;
        end
        tick();
        rd_release = 1'b0;
        repeat (2) tick();
        @(negedge pclk);
        chk("busy_after", int'(busy), int'(m_armed));
        chk("rdy_after", int'(frame_rdy), int'(m_rdy));
    endtask

    initial begin
        int pl[4];
        int kind;
        do_reset();
        tick();

        // Good frame
        req();
        @(negedge pclk);
        chk("busy_armed", int'(busy), 1);
        frame(3, '{4, 4, 4, 0}, 1'b0, 1'b0);
        release_rd();

        // Armed mid-frame: first frame skipped, next one captured
        frame(3, '{4, 4, 4, 0}, 1'b0, 1'b1);
        frame(3, '{4, 4, 4, 0}, 1'b0, 1'b0);
        release_rd();

        // Short frame
        req();
        frame(3, '{4, 4, 3, 0}, 1'b0, 1'b0);

        // Consumer busy: swap, drop, then swap with release at commit
        req();
        frame(3, '{4, 4, 4, 0}, 1'b0, 1'b0);
        req();
        frame(3, '{4, 4, 4, 0}, 1'b0, 1'b0);
        req();
        frame(3, '{4, 4, 4, 0}, 1'b1, 1'b0);

        // Reset during capture after 5 pixels
        if (!CONT) begin
            req();
            vsync = 1'b1;
            repeat (3) tick();
            vsync = 1'b0;
            m_capt = 1;
            m_armed = 0;
            tick();
            exp_wr_en = 1'b1;
            href = 1'b1;
            tick();
            repeat (5) begin
                pix_we = 1'b1;
                tick();
                pix_we = 1'b0;
            end
            do_reset();
            href = 1'b0;
            repeat (3) tick();
            req();
            frame(3, '{4, 4, 4, 0}, 1'b0, 1'b0);
            release_rd();
        end

        // Randomized frames
        for (int i = 0; i < 10; i++) begin
            pl = '{4, 4, 4, 0};
            kind = $urandom_range(0, 4);
            if (kind == 2) pl[$urandom_range(0, 2)] -= 1;
            if (kind == 3) pl[$urandom_range(0, 2)] += 1;
            if ($urandom_range(0, 1) == 1 && m_rdy) release_rd();
            if (!CONT || !m_armed) req();
            frame(kind == 4 ? 2 : 3, pl, 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef CAP_CONTINUOUS_EN
        // Continuous: three swaps from one request, stop during third
        do_reset();
        tick();
        req();
        frame(3, '{4, 4, 4, 0}, 1'b0, 1'b0);
        chk("cont_bank1", int'(wr_bank), 1);
        release_rd();
        frame(3, '{4, 4, 4, 0}, 1'b0, 1'b0);
        chk("cont_bank2", int'(wr_bank), 0);
        release_rd();
        frame(3, '{4, 4, 4, 0}, 1'b0, 1'b1);
        chk("cont_bank3", int'(wr_bank), 1);
        release_rd();
        chk("cont_idle", int'(busy), 0);
        frame(3, '{4, 4, 4, 0}, 1'b0, 1'b0);
        chk("cont_nocap", int'(wr_bank), 1);
`endif

        repeat (4) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ov7670_capture_ctrl.md
# ov7670_capture_ctrl

Frame capture sequencer for the OV7670 camera path, running in the `pclk` domain next to the pixel-to-memory writer. It arms on a host capture request and waits for a clean frame start. It then gates the writer's memory writes for exactly one frame and checks the line and pixel counts. Good frames are committed by swapping a two-bank (ping-pong) frame buffer, so the downstream consumer never reads a frame that is still being written.

## Interface
- `IMG_WIDTH`, default 320: pixels per line.
- `IMG_HEIGHT`, default 240: lines per frame.
- `PIX_CNT_W`, default `$clog2(IMG_WIDTH*IMG_HEIGHT+1)`: pixel counter width.
- `LINE_CNT_W`, default `$clog2(IMG_HEIGHT+1)`: line counter width.

- `pclk`  in  1  camera pixel clock; every register is on its rising edge.
- `reset`  in  1  reset, synchronous, active-high; clock `pclk`.
- `vsync`  in  1  camera VSYNC; high means vertical blanking.
- `href`  in  1  camera HREF; high means a line is active.
- `pix_we`  in  1  one-cycle strobe from the pixel writer for each completed pixel.
- `cap_req`  in  1  one-cycle request to capture the next full frame.
- `rd_release`  in  1  one-cycle pulse from the consumer: it is done with the read bank.
- `wr_en`  out  1  gate ANDed with the writer's `we`.
- `wr_bank`  out  1  bank the writer targets.
- `rd_bank`  out  1  bank the consumer reads; always equal to `~wr_bank`.
- `frame_rdy`  out  1  the read bank holds a committed frame that has not been released.
- `frame_err`  out  1  one-cycle pulse: the captured frame had the wrong line or pixel count.
- `frame_drop`  out  1  one-cycle pulse: a good frame was discarded because the read bank was not released.
- `busy`  out  1  high whenever the state is not IDLE.
- `line_cnt`  out  `LINE_CNT_W`  number of lines counted in the current or last capture.

## Operation
- Edge detect: `vsync_q` and `href_q` are registered copies, reset to 0.
  - `vs_fall = vsync_q & ~vsync`
  - `vs_rise = ~vsync_q & vsync`
  - `href_rise = ~href_q & href`
- IDLE:
  - `cap_req` moves the state to ARM.
- ARM:
  - Wait for `vs_fall`, then go to CAPTURE and clear `line_cnt` and `pix_cnt`.
  - Arming mid-frame therefore never captures a partial frame.
- CAPTURE:
  - `href_rise` increments `line_cnt`; `pix_we` increments `pix_cnt`. Both counters saturate at their maximum.
  - `vs_rise` moves the state to COMMIT.
- COMMIT (lasts one cycle):
  - The frame is good when `line_cnt == IMG_HEIGHT` and `pix_cnt == IMG_WIDTH*IMG_HEIGHT`.
  - Bad frame: pulse `frame_err`; no swap.
  - Good frame, and (`frame_rdy == 0` or `rd_release` in this cycle): toggle `wr_bank` and set `frame_rdy` to 1.
  - Good frame, and `frame_rdy == 1` with no release: pulse `frame_drop`; no swap.
  - Next state is IDLE (see Configuration).
- `cap_req` is ignored outside IDLE.
- `rd_release` clears `frame_rdy` on the next edge. When `frame_rdy == 0`, `rd_release` is ignored.
- Release and good commit in the same cycle: the release is honored, the banks swap, and `frame_rdy` stays 1.
- Reset values:
  - state IDLE
  - `wr_bank` 0, `rd_bank` 1
  - `wr_en`, `frame_rdy`, `frame_err`, `frame_drop`, `busy` all 0
  - `line_cnt` 0, `pix_cnt` 0
- Reset mid-capture aborts the frame and leaves no swap and no pulse.

## Timing
- `wr_en` and `busy` are decoded from the state register, so they carry no combinational path from the inputs.
- `wr_en` rises in the first cycle after the edge that samples `vs_fall`, and falls in the first cycle after the edge that samples `vs_rise`.
- `frame_err` and `frame_drop` are registered. They are high for exactly the one cycle after COMMIT.
- `wr_bank`, `rd_bank` and `frame_rdy` change on the edge that leaves COMMIT.
- Latency from the `vsync` rising edge at the pins to the bank swap is 2 `pclk` cycles.
- `pix_we` and `href_rise` are counted only while the state is CAPTURE.

## Configuration
- `CAP_CONTINUOUS_EN` defined: COMMIT goes to ARM, so the block captures every frame after a single `cap_req`.
  - A `cap_req` in ARM, CAPTURE or COMMIT stops continuous mode: the block returns to IDLE after the current COMMIT.
- `CAP_CONTINUOUS_EN` undefined: single-shot. COMMIT always goes to IDLE.

## Test plan
Bench parameters are `IMG_WIDTH=4`, `IMG_HEIGHT=3`.
- Good frame: `cap_req`, then a frame with 3 lines of 4 `pix_we` each.
  - Required: `wr_en` high only between the `vsync` edges.
  - `wr_bank` becomes 1, `rd_bank` 0, `frame_rdy` 1, `line_cnt` 3, no pulses.
- Armed mid-frame: `cap_req` while `vsync` is low and `href` lines are active.
  - Required: no capture until the next `vsync` fall; then exactly one full frame is committed.
- Short frame: 11 `pix_we` instead of 12.
  - Required: one-cycle `frame_err` pulse, banks unchanged, `frame_rdy` 0.
- Consumer busy: a second good frame while `frame_rdy` is 1 → `frame_drop` pulses and the banks do not change.
  - Repeat with `rd_release` in the COMMIT cycle → swap occurs and `frame_rdy` stays 1.
- Reset during CAPTURE after 5 pixels → all outputs return to their reset values; a following clean frame commits normally.
- With `CAP_CONTINUOUS_EN`: one `cap_req`, three good frames with `rd_release` after each → three swaps (`wr_bank` reads 1, 0, 1).
  - A `cap_req` during the third frame → IDLE after its COMMIT.
